// File: rtl/rv_pkg.sv
// Shared RV core types and constants used by the memory arbiter and its ID FIFO.
package rv_pkg;

  localparam int XLEN = 32;
  localparam logic [3:0] RV_BE_FULL = 4'hF;

  typedef enum logic {RV_ID_INSTR, RV_ID_DATA} rv_mem_id_e;

endpackage

// File: rtl/rv_id_fifo.sv
// In-order tracker of which requester issued each outstanding memory transaction.
module rv_id_fifo
  import rv_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk_i,
  input  logic             arstn_i,
  input  logic             push,
  input  rv_mem_id_e       push_id,
  input  logic             pop,
  output rv_mem_id_e       head,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  rv_mem_id_e       slots [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + 1'b1;
  endfunction

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot the push needs, so a full FIFO may still accept.
  assign do_push = push && (!full || do_pop);
  assign head    = slots[rd_ptr];

  always_ff @(posedge clk_i) begin
    if (do_push) slots[wr_ptr] <= push_id;
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wrap_inc(wr_ptr);
      if (do_pop)  rd_ptr <= wrap_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/rv_mem_arbiter.sv
// Round-robin arbiter sharing one memory port between instruction fetch and the LSU,
// routing in-order responses back to the requester that issued them.
module rv_mem_arbiter
  import rv_pkg::*;
#(
  parameter int MAX_OUTST = 2,
  parameter int ADDR_W    = XLEN
) (
  input  logic              clk_i,
  input  logic              arstn_i,
  input  logic              instr_req_i,
  input  logic [ADDR_W-1:0] instr_addr_i,
  output logic              instr_gnt_o,
  output logic              instr_rvalid_o,
  output logic [XLEN-1:0]   instr_rdata_o,
  input  logic              data_req_i,
  input  logic              data_we_i,
  input  logic [3:0]        data_be_i,
  input  logic [ADDR_W-1:0] data_addr_i,
  input  logic [XLEN-1:0]   data_wdata_i,
  output logic              data_gnt_o,
  output logic              data_rvalid_o,
  output logic [XLEN-1:0]   data_rdata_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [3:0]        mem_be_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [XLEN-1:0]   mem_wdata_o,
  input  logic              mem_gnt_i,
  input  logic              mem_rvalid_i,
  input  logic [XLEN-1:0]   mem_rdata_i,
  output logic              err_o
);

  localparam int CNT_W = $clog2(MAX_OUTST + 1);

  rv_mem_id_e       sel, last_id, locked_id, head;
  logic             locked, handshake, pop, spurious;
  logic             fifo_full, fifo_empty;
  logic [CNT_W-1:0] fifo_count;

  // A stalled request keeps its port until memory takes it; otherwise alternate on ties.
  always_comb begin
    sel = RV_ID_INSTR;
    if (locked) begin
      sel = locked_id;
    end else if (instr_req_i && data_req_i) begin
      sel = (last_id == RV_ID_INSTR) ? RV_ID_DATA : RV_ID_INSTR;
    end else if (data_req_i) begin
      sel = RV_ID_DATA;
    end
  end

  // Gating uses only registered occupancy, so a response never frees a slot combinationally.
  assign mem_req_o = arstn_i && (instr_req_i || data_req_i) && !fifo_full;
  assign handshake = mem_req_o && mem_gnt_i;

  always_comb begin
    mem_we_o    = 1'b0;
    mem_be_o    = '0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if (mem_req_o) begin
      if (sel == RV_ID_DATA) begin
        mem_we_o    = data_we_i;
        mem_be_o    = data_be_i;
        mem_addr_o  = data_addr_i;
        mem_wdata_o = data_wdata_i;
      end else begin
        mem_be_o   = RV_BE_FULL;
        mem_addr_o = instr_addr_i;
      end
    end
  end

  assign instr_gnt_o = handshake && (sel == RV_ID_INSTR);
  assign data_gnt_o  = handshake && (sel == RV_ID_DATA);

  assign spurious       = mem_rvalid_i && (fifo_count == '0);
  assign pop            = mem_rvalid_i && !fifo_empty;
  assign instr_rvalid_o = pop && (head == RV_ID_INSTR);
  assign data_rvalid_o  = pop && (head == RV_ID_DATA);
  assign instr_rdata_o  = instr_rvalid_o ? mem_rdata_i : '0;
  assign data_rdata_o   = data_rvalid_o  ? mem_rdata_i : '0;

  rv_id_fifo #(.DEPTH(MAX_OUTST)) u_id_fifo (
    .clk_i   (clk_i),
    .arstn_i (arstn_i),
    .push    (handshake),
    .push_id (sel),
    .pop     (pop),
    .head    (head),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // last_id starts at DATA so the first tie after reset goes to instruction fetch.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      last_id   <= RV_ID_DATA;
      locked    <= 1'b0;
      locked_id <= RV_ID_INSTR;
      err_o     <= 1'b0;
    end else begin
      if (handshake) last_id <= sel;
      locked <= mem_req_o && !mem_gnt_i;
      if (mem_req_o && !mem_gnt_i) locked_id <= sel;
      if (spurious) err_o <= 1'b1;
    end
  end

endmodule
